// File: rtl/dbgregfile.sv
// Debug-write responder with a shadow/active configuration register file committed at vsync.
// Optional write lock at address 0xFD is enabled by defining DBGREGFILE_WRLOCK_EN.
module dbgregfile #(
    parameter int unsigned NREG = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        dbgaddr,
    input  logic [7:0]        dbgwdata,
    input  logic              dbgreq,
    output logic              dbgack,
    input  logic              vsync,
    output logic [8*NREG-1:0] cfg,
    output logic              pending,
    output logic              cfgupd,
    output logic [7:0]        errcnt
);

    localparam int unsigned IdxW  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [7:0]  NregB = 8'(NREG);

    typedef enum logic [1:0] {StIdle, StExec, StAck, StHold} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              addr_q, wdata_q;
    logic                    latch_en, exec;
    logic [NREG-1:0][7:0]    shadow_q, shadow_d;
    logic [NREG-1:0][7:0]    active_q, active_d;
    logic                    pending_q, pending_d;
    logic                    cfgupd_q, cfgupd_d;
    logic [7:0]              errcnt_q, errcnt_d;
    logic [IdxW-1:0]         idx;
    logic                    wr_ok, is_reg, is_commit, is_abort, is_lock;
    logic                    do_reg, do_commit, do_abort, do_err, commit_now;

    // Handshake FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                addr_q  <= dbgaddr;
                wdata_q <= dbgwdata;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        exec     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dbgreq) begin
                    latch_en = 1'b1;
                    state_d  = StExec;
                end
            end
            StExec: begin
                exec    = 1'b1;
                state_d = StAck;
            end
            StAck:  state_d = StHold;
            // dbgreq is still high just after the ack; wait for it to drop
            StHold: begin
                if (!dbgreq) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign dbgack = (state_q == StAck);

`ifdef DBGREGFILE_WRLOCK_EN
    logic locked_q, locked_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) locked_q <= 1'b1;
        else       locked_q <= locked_d;
    end

    always_comb begin
        locked_d = locked_q;
        if (exec && is_lock) locked_d = (wdata_q != 8'hA5);
    end

    assign is_lock = (addr_q == 8'hFD);
    assign wr_ok   = !locked_q;
`else
    assign is_lock = 1'b0;
    assign wr_ok   = 1'b1;
`endif

    // Address decode of the latched request
    assign idx        = addr_q[IdxW-1:0];
    assign is_reg     = (addr_q < NregB);
    assign is_commit  = (addr_q == 8'hFE);
    assign is_abort   = (addr_q == 8'hFF);
    assign do_reg     = exec && wr_ok && is_reg;
    assign do_commit  = exec && wr_ok && is_commit;
    assign do_abort   = exec && wr_ok && is_abort;
    assign do_err     = exec && !(do_reg || do_commit || do_abort || is_lock);
    assign commit_now = vsync && pending_q;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        errcnt_d  = errcnt_q;
        cfgupd_d  = commit_now;
        if (commit_now) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (do_reg) shadow_d[idx] = wdata_q;
        if (do_abort) begin
            pending_d = 1'b0;
            // A coinciding commit already made active equal shadow; keep shadow as is
            if (!commit_now) shadow_d = active_q;
        end
        // A fresh commit request outranks the clear from a coinciding vsync
        if (do_commit) pending_d = 1'b1;
        if (do_err && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'h01;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            cfgupd_q  <= 1'b0;
            errcnt_q  <= 8'h00;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            cfgupd_q  <= cfgupd_d;
            errcnt_q  <= errcnt_d;
        end
    end

    assign cfg     = active_q;
    assign pending = pending_q;
    assign cfgupd  = cfgupd_q;
    assign errcnt  = errcnt_q;

endmodule

// File: tb/tb_dbgregfile.sv
// Directed self-checking bench for dbgregfile (default NREG = 16).
module tb_dbgregfile;

    localparam int unsigned NREG = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [7:0]        dbgaddr = 8'h00;
    logic [7:0]        dbgwdata = 8'h00;
    logic              dbgreq = 1'b0;
    logic              dbgack;
    logic              vsync = 1'b0;
    logic [8*NREG-1:0] cfg;
    logic              pending;
    logic              cfgupd;
    logic [7:0]        errcnt;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_cnt  = 0;
    int upd_cnt  = 0;
    int base;
    int lat;

    dbgregfile #(.NREG(NREG)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .dbgaddr  (dbgaddr),
        .dbgwdata (dbgwdata),
        .dbgreq   (dbgreq),
        .dbgack   (dbgack),
        .vsync    (vsync),
        .cfg      (cfg),
        .pending  (pending),
        .cfgupd   (cfgupd),
        .errcnt   (errcnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dbgack) ack_cnt <= ack_cnt + 1;
        if (cfgupd) upd_cnt <= upd_cnt + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // All tasks start and end on a falling edge.
    task automatic do_reset;
        rstn   = 1'b0;
        dbgreq = 1'b0;
        vsync  = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // Ack is expected at the second falling edge after dbgreq is raised (third cycle
    // counting the cycle in which dbgreq is first sampled).
    task automatic wr(input logic [7:0] a, input logic [7:0] d, input bit vs_exec,
                      input int hold);
        int n;
        dbgaddr  = a;
        dbgwdata = d;
        dbgreq   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            vsync = (n == 1) && vs_exec;
        end while (!dbgack && n < 12);
        vsync = 1'b0;
        check("ack_latency", 128'(n), 128'(2));
        repeat (1 + hold) @(negedge clk);
        dbgreq = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_vsync;
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_cfg", 128'(cfg), 128'(0));
        check("rst_ack", 128'(dbgack), 128'(0));
        check("rst_pending", 128'(pending), 128'(0));
        check("rst_cfgupd", 128'(cfgupd), 128'(0));
        check("rst_errcnt", 128'(errcnt), 128'(0));

        // 1: basic write, commit, vsync
        base = ack_cnt;
        wr(8'h03, 8'h5A, 1'b0, 0);
        check("t1_one_ack", 128'(ack_cnt - base), 128'(1));
        check("t1_cfg_before", 128'(cfg[31:24]), 128'(8'h00));
        wr(8'hFE, 8'h00, 1'b0, 0);
        check("t1_pending", 128'(pending), 128'(1));
        check("t1_cfg_pend", 128'(cfg[31:24]), 128'(8'h00));
        base = upd_cnt;
        pulse_vsync();
        check("t1_cfg_after", 128'(cfg[31:24]), 128'(8'h5A));
        check("t1_cfgupd_hi", 128'(cfgupd), 128'(1));
        check("t1_pending_clr", 128'(pending), 128'(0));
        repeat (3) @(negedge clk);
        check("t1_cfgupd_once", 128'(upd_cnt - base), 128'(1));
        check("t1_cfgupd_lo", 128'(cfgupd), 128'(0));

        // 2: request held long after ack is serviced once
        do_reset();
        base = ack_cnt;
        wr(8'h90, 8'h00, 1'b0, 10);
        check("t2_one_ack", 128'(ack_cnt - base), 128'(1));
        check("t2_one_write", 128'(errcnt), 128'(1));
        wr(8'h90, 8'h00, 1'b0, 0);
        check("t2_second_ack", 128'(ack_cnt - base), 128'(2));
        check("t2_errcnt", 128'(errcnt), 128'(2));

        // 3: shadow write coinciding with commit copies pre-write value
        do_reset();
        wr(8'h01, 8'h11, 1'b0, 0);
        wr(8'hFE, 8'h00, 1'b0, 0);
        base = upd_cnt;
        wr(8'h01, 8'h22, 1'b1, 0);
        check("t3_cfg_old", 128'(cfg[15:8]), 128'(8'h11));
        check("t3_pending", 128'(pending), 128'(0));
        check("t3_upd", 128'(upd_cnt - base), 128'(1));
        wr(8'hFE, 8'h00, 1'b0, 0);
        pulse_vsync();
        check("t3_cfg_new", 128'(cfg[15:8]), 128'(8'h22));

        // 3b: commit request on the vsync cycle waits for the next frame
        do_reset();
        wr(8'h05, 8'h44, 1'b0, 0);
        wr(8'hFE, 8'h00, 1'b1, 0);
        check("t3b_pending", 128'(pending), 128'(1));
        check("t3b_cfg_hold", 128'(cfg[47:40]), 128'(8'h00));
        pulse_vsync();
        check("t3b_cfg", 128'(cfg[47:40]), 128'(8'h44));

        // 3c: abort on a pending vsync loses to the commit; shadow equals active after
        wr(8'h06, 8'h66, 1'b0, 0);
        wr(8'hFE, 8'h00, 1'b0, 0);
        wr(8'hFF, 8'h00, 1'b1, 0);
        check("t3c_cfg", 128'(cfg[55:48]), 128'(8'h66));
        check("t3c_pending", 128'(pending), 128'(0));
        wr(8'hFE, 8'h00, 1'b0, 0);
        pulse_vsync();
        check("t3c_shadow_eq", 128'(cfg[55:48]), 128'(8'h66));

        // 4: abort restores shadow from active
        do_reset();
        wr(8'h00, 8'h77, 1'b0, 0);
        wr(8'hFE, 8'h00, 1'b0, 0);
        check("t4_pending_set", 128'(pending), 128'(1));
        wr(8'hFF, 8'h00, 1'b0, 0);
        check("t4_pending_clr", 128'(pending), 128'(0));
        base = upd_cnt;
        pulse_vsync();
        @(negedge clk);
        check("t4_no_upd", 128'(upd_cnt - base), 128'(0));
        wr(8'hFE, 8'h00, 1'b0, 0);
        pulse_vsync();
        check("t4_cfg_zero", 128'(cfg), 128'(0));

        // 5: errcnt saturation, then reset mid-EXEC
        do_reset();
        wr(8'h00, 8'h99, 1'b0, 0);
        wr(8'hFE, 8'h00, 1'b0, 0);
        pulse_vsync();
        check("t5_cfg_pre", 128'(cfg[7:0]), 128'(8'h99));
        wr(8'hFE, 8'h00, 1'b0, 0);
        base = ack_cnt;
        for (int i = 0; i < 300; i++) wr(8'h80, 8'(i), 1'b0, 0);
        check("t5_acks", 128'(ack_cnt - base), 128'(300));
        check("t5_errcnt_sat", 128'(errcnt), 128'(8'hFF));
        dbgaddr = 8'h80;
        dbgreq  = 1'b1;
        @(negedge clk);
        base = ack_cnt;
        rstn = 1'b0;
        #1;
        check("t5_rst_ack", 128'(dbgack), 128'(0));
        check("t5_rst_cfg", 128'(cfg), 128'(0));
        check("t5_rst_pending", 128'(pending), 128'(0));
        check("t5_rst_errcnt", 128'(errcnt), 128'(0));
        check("t5_rst_cfgupd", 128'(cfgupd), 128'(0));
        repeat (3) @(negedge clk);
        check("t5_no_ack_in_rst", 128'(ack_cnt - base), 128'(0));
        rstn = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!dbgack && lat < 12);
        check("t5_reservice_lat", 128'(lat), 128'(2));
        @(negedge clk);
        dbgreq = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_reservice_ack", 128'(ack_cnt - base), 128'(1));
        check("t5_reservice_err", 128'(errcnt), 128'(1));

        // 6: lock register
        do_reset();
`ifdef DBGREGFILE_WRLOCK_EN
        wr(8'h02, 8'h33, 1'b0, 0);
        check("t6_locked_err", 128'(errcnt), 128'(1));
        wr(8'hFE, 8'h00, 1'b0, 0);
        check("t6_locked_commit", 128'(pending), 128'(0));
        check("t6_locked_err2", 128'(errcnt), 128'(2));
        wr(8'hFD, 8'hA5, 1'b0, 0);
        check("t6_unlock_noerr", 128'(errcnt), 128'(2));
        wr(8'h02, 8'h33, 1'b0, 0);
        wr(8'hFE, 8'h00, 1'b0, 0);
        pulse_vsync();
        check("t6_cfg", 128'(cfg[23:16]), 128'(8'h33));
        wr(8'hFD, 8'h00, 1'b0, 0);
        wr(8'h02, 8'h44, 1'b0, 0);
        check("t6_relock_err", 128'(errcnt), 128'(3));
`else
        wr(8'hFD, 8'hA5, 1'b0, 0);
        check("t6_fd_unmapped", 128'(errcnt), 128'(1));
        wr(8'h02, 8'h33, 1'b0, 0);
        wr(8'hFE, 8'h00, 1'b0, 0);
        pulse_vsync();
        check("t6_cfg", 128'(cfg[23:16]), 128'(8'h33));
        check("t6_errcnt", 128'(errcnt), 128'(1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
